// File: rtl/edisk_mapper.sv
// edisk_mapper: maps CPU memory cycles onto extended RAM-disk pages.
// Each disk has one I/O control register selecting a stack page and a
// window page; the lowest-index disk that hits drives ed_page.
module edisk_mapper #(
  parameter int          NUM_DISKS  = 1,
  parameter int unsigned PORT_BASE  = 8'h10,
  parameter bit          EXT_WINDOW = 1'b0,
  localparam int         PW         = $clog2(4*NUM_DISKS+1)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [7:0]    io_addr,
  input  logic          io_wr,
  input  logic          io_rd,
  input  logic [7:0]    din,
  input  logic [15:0]   addr,
  input  logic          ram_read,
  input  logic          write_n,
  input  logic          io_stack,
  output logic [PW-1:0] ed_page,
  output logic [7:0]    dout,
  output logic          sel,
  output logic          conflict
);

  // Elaboration-time parameter sanity: disk count and port range must fit.
  if (NUM_DISKS < 1 || NUM_DISKS > 8) begin : g_bad_num_disks
    $error("edisk_mapper: NUM_DISKS must be 1..8");
  end
  if (PORT_BASE + NUM_DISKS - 1 > 255) begin : g_bad_port_range
    $error("edisk_mapper: PORT_BASE+NUM_DISKS-1 exceeds 8'hFF");
  end

  logic [7:0]           disk_reg [NUM_DISKS];
  logic                 io_wr_prev;
  logic [NUM_DISKS-1:0] port_hit;
  logic [NUM_DISKS-1:0] disk_hit;
  logic [1:0]           disk_page [NUM_DISKS];
  logic                 mreq;
  logic                 wr_fire;
  logic                 multi_hit;

  // Low address bits never take part in window decoding.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[12:0];

  assign mreq    = ram_read | ~write_n;
  assign wr_fire = io_wr & ~io_wr_prev;
  assign sel     = |port_hit;

  // Per-disk port decode and memory hit/page decode.
  for (genvar gi = 0; gi < NUM_DISKS; gi++) begin : g_disk
    logic stack_hit;
    logic win_hit;
    logic win_main;
    logic win_ext;

    assign port_hit[gi] = (io_addr == 8'(PORT_BASE + gi));
    assign stack_hit    = disk_reg[gi][4] & io_stack & mreq;
    assign win_main     = disk_reg[gi][5] & addr[15] & (addr[14] ^ addr[13]);
    assign win_ext      = EXT_WINDOW & disk_reg[gi][6] & (addr[15:13] == 3'b100);
    assign win_hit      = mreq & ~stack_hit & (win_main | win_ext);
    assign disk_hit[gi] = stack_hit | win_hit;
    // Stack page wins inside a disk because win_hit is masked by stack_hit.
    assign disk_page[gi] = stack_hit ? disk_reg[gi][3:2] : disk_reg[gi][1:0];
  end

  assign multi_hit = ($countones(disk_hit) > 1);

  // Priority select: iterate high to low so the lowest-index hit overrides.
  always_comb begin
    ed_page = '0;
    for (int d = NUM_DISKS - 1; d >= 0; d--) begin
      if (disk_hit[d]) begin
        ed_page = PW'(1 + 4*d + int'(disk_page[d]));
      end
    end
  end

  // Register readback; unselected or idle ports float high like an open bus.
  always_comb begin
    dout = 8'hFF;
    if (io_rd && sel) begin
      for (int d = 0; d < NUM_DISKS; d++) begin
        if (port_hit[d]) begin
          dout = disk_reg[d];
        end
      end
    end
  end

  // Register file, write edge detector and sticky conflict flag.
  // io_wr_prev resets high so a level held across reset release never writes.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      io_wr_prev <= 1'b1;
      conflict   <= 1'b0;
      for (int d = 0; d < NUM_DISKS; d++) begin
        disk_reg[d] <= 8'h00;
      end
    end else begin
      io_wr_prev <= io_wr;
      for (int d = 0; d < NUM_DISKS; d++) begin
        if (wr_fire && port_hit[d]) begin
          disk_reg[d] <= din;
        end
      end
      if (multi_hit) begin
        conflict <= 1'b1;
      end else if (wr_fire && sel) begin
        conflict <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_edisk_mapper.sv
// Self-checking bench for edisk_mapper: three configurations share one bus
// (1 disk, 4 disks, 1 disk with the 8000-9FFF window enabled).
module tb_edisk_mapper;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [7:0]  io_addr;
  logic        io_wr;
  logic        io_rd;
  logic [7:0]  din;
  logic [15:0] addr;
  logic        ram_read;
  logic        write_n;
  logic        io_stack;

  logic [2:0]  ed1, ede;
  logic [4:0]  ed4;
  logic [7:0]  dout1, dout4, doute;
  logic        sel1, sel4, sele;
  logic        conf1, conf4, confe;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  ev;

  always #5 clk_sys = ~clk_sys;

  edisk_mapper #(.NUM_DISKS(1), .PORT_BASE(8'h10), .EXT_WINDOW(1'b0)) u1 (
    .clk_sys(clk_sys), .reset(reset), .io_addr(io_addr), .io_wr(io_wr), .io_rd(io_rd),
    .din(din), .addr(addr), .ram_read(ram_read), .write_n(write_n), .io_stack(io_stack),
    .ed_page(ed1), .dout(dout1), .sel(sel1), .conflict(conf1));

  edisk_mapper #(.NUM_DISKS(4), .PORT_BASE(8'h10), .EXT_WINDOW(1'b0)) u4 (
    .clk_sys(clk_sys), .reset(reset), .io_addr(io_addr), .io_wr(io_wr), .io_rd(io_rd),
    .din(din), .addr(addr), .ram_read(ram_read), .write_n(write_n), .io_stack(io_stack),
    .ed_page(ed4), .dout(dout4), .sel(sel4), .conflict(conf4));

  edisk_mapper #(.NUM_DISKS(1), .PORT_BASE(8'h10), .EXT_WINDOW(1'b1)) ue (
    .clk_sys(clk_sys), .reset(reset), .io_addr(io_addr), .io_wr(io_wr), .io_rd(io_rd),
    .din(din), .addr(addr), .ram_read(ram_read), .write_n(write_n), .io_stack(io_stack),
    .ed_page(ede), .dout(doute), .sel(sele), .conflict(confe));

  // One-cycle I/O write pulse: the edge after io_wr rises performs the write.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk_sys); #1;
    io_addr = a; din = d; io_wr = 1'b1;
    @(posedge clk_sys); #1;
    io_wr = 1'b0;
  endtask

  // Drive one memory-bus cycle and move to the sampling point (falling edge).
  task automatic bus(input logic [15:0] a, input logic rr, input logic wn, input logic st);
    @(posedge clk_sys); #1;
    addr = a; ram_read = rr; write_n = wn; io_stack = st;
    @(negedge clk_sys);
  endtask

  task automatic test_reset;
    logic [15:0] addrs [5] = '{16'h8000, 16'hA000, 16'hC000, 16'hE000, 16'h9000};
    reset = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    io_addr = 8'h10; io_rd = 1'b1;
    @(negedge clk_sys);
    exp_q.push_back(8'h00);
    ev = exp_q.pop_front(); total++;
    if (dout1 !== ev) begin bad++; $display("FAIL reset_dout got=%h want=%h", dout1, ev); end
    else $display("ok   reset_dout dout=%h", dout1);
    exp_q.push_back(8'h01);
    ev = exp_q.pop_front(); total++;
    if ({7'b0, sel1} !== ev) begin bad++; $display("FAIL reset_sel got=%b want=%h", sel1, ev); end
    else $display("ok   reset_sel sel=%b", sel1);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h00);
      bus(addrs[i], 1'b1, 1'b1, i[0]);
      ev = exp_q.pop_front(); total++;
      if ({5'b0, ed1} !== ev || {3'b0, ed4} !== ev || {5'b0, ede} !== ev || conf4 !== 1'b0) begin
        bad++;
        $display("FAIL reset_page addr=%h got=%0d/%0d/%0d conf=%b want=%0d", addrs[i], ed1, ed4, ede, conf4, ev);
      end else $display("ok   reset_page addr=%h ed_page=0", addrs[i]);
    end
    ram_read = 1'b0; io_stack = 1'b0; io_rd = 1'b0;
  endtask

  task automatic test_window;
    logic [15:0] addrs [7] = '{16'hC000, 16'h8000, 16'hA000, 16'hE000, 16'h6000, 16'hC000, 16'hC000};
    logic        rrs   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        wns   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0]  exps  [7] = '{8'd3, 8'd0, 8'd3, 8'd0, 8'd0, 8'd3, 8'd0};
    // io_wr held high for five cycles while din changes after the first edge.
    @(posedge clk_sys); #1;
    io_addr = 8'h10; din = 8'h22; io_wr = 1'b1;
    @(posedge clk_sys); #1;
    din = 8'h55;
    repeat (4) @(posedge clk_sys);
    #1 io_wr = 1'b0; io_rd = 1'b1;
    exp_q.push_back(8'h22);
    @(negedge clk_sys);
    ev = exp_q.pop_front(); total++;
    if (dout1 !== ev) begin bad++; $display("FAIL single_write got=%h want=%h", dout1, ev); end
    else $display("ok   single_write dout=%h", dout1);
    io_rd = 1'b0;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(exps[i]);
      bus(addrs[i], rrs[i], wns[i], 1'b0);
      ev = exp_q.pop_front(); total++;
      if ({5'b0, ed1} !== ev || {3'b0, ed4} !== ev) begin
        bad++; $display("FAIL window addr=%h rr=%b wn=%b got=%0d/%0d want=%0d", addrs[i], rrs[i], wns[i], ed1, ed4, ev);
      end else $display("ok   window addr=%h ed_page=%0d", addrs[i], ed1);
    end
    ram_read = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_stack;
    logic [7:0]  regs  [6] = '{8'h3D, 8'h3D, 8'h3D, 8'h1D, 8'h1D, 8'h3D};
    logic [15:0] addrs [6] = '{16'hA000, 16'hA000, 16'h6000, 16'hA000, 16'hA000, 16'hA000};
    logic        rrs   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        sts   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0]  exps  [6] = '{8'd4, 8'd2, 8'd4, 8'd4, 8'd0, 8'd0};
    for (int i = 0; i < 6; i++) begin
      wr(8'h10, regs[i]);
      exp_q.push_back(exps[i]);
      bus(addrs[i], rrs[i], 1'b1, sts[i]);
      ev = exp_q.pop_front(); total++;
      if ({5'b0, ed1} !== ev) begin
        bad++; $display("FAIL stack reg=%h addr=%h st=%b got=%0d want=%0d", regs[i], addrs[i], sts[i], ed1, ev);
      end else $display("ok   stack reg=%h addr=%h st=%b ed_page=%0d", regs[i], addrs[i], sts[i], ed1);
      ram_read = 1'b0; io_stack = 1'b0;
    end
  endtask

  task automatic test_multi;
    wr(8'h10, 8'h00); wr(8'h11, 8'h21); wr(8'h12, 8'h23);
    exp_q.push_back(8'd6);
    bus(16'hA000, 1'b1, 1'b1, 1'b0);
    ev = exp_q.pop_front(); total++;
    if ({3'b0, ed4} !== ev) begin bad++; $display("FAIL multi_prio got=%0d want=%0d", ed4, ev); end
    else $display("ok   multi_prio ed_page=%0d", ed4);
    exp_q.push_back(8'h01);
    @(negedge clk_sys);
    ev = exp_q.pop_front(); total++;
    if ({7'b0, conf4} !== ev) begin bad++; $display("FAIL conflict_set got=%b want=%h", conf4, ev); end
    else $display("ok   conflict_set conflict=%b", conf4);
    exp_q.push_back(8'h01);
    bus(16'h0000, 1'b0, 1'b1, 1'b0);
    @(negedge clk_sys);
    ev = exp_q.pop_front(); total++;
    if ({7'b0, conf4} !== ev || conf1 !== 1'b0) begin bad++; $display("FAIL conflict_sticky got=%b/%b want=%h", conf4, conf1, ev); end
    else $display("ok   conflict_sticky conflict=%b", conf4);
    exp_q.push_back(8'h00);
    wr(8'h13, 8'h00);
    @(negedge clk_sys);
    ev = exp_q.pop_front(); total++;
    if ({7'b0, conf4} !== ev) begin bad++; $display("FAIL conflict_clear got=%b want=%h", conf4, ev); end
    else $display("ok   conflict_clear conflict=%b", conf4);
    // A register write landing on a cycle with a multi-hit must leave the flag set.
    exp_q.push_back(8'h01);
    @(posedge clk_sys); #1;
    addr = 16'hA000; ram_read = 1'b1; io_addr = 8'h13; din = 8'h00; io_wr = 1'b1;
    @(posedge clk_sys); #1;
    io_wr = 1'b0; ram_read = 1'b0;
    @(negedge clk_sys);
    ev = exp_q.pop_front(); total++;
    if ({7'b0, conf4} !== ev) begin bad++; $display("FAIL conflict_set_wins got=%b want=%h", conf4, ev); end
    else $display("ok   conflict_set_wins conflict=%b", conf4);
    wr(8'h11, 8'h00);
    exp_q.push_back(8'd12);
    bus(16'hA000, 1'b1, 1'b1, 1'b0);
    ev = exp_q.pop_front(); total++;
    if ({3'b0, ed4} !== ev) begin bad++; $display("FAIL multi_disk2 got=%0d want=%0d", ed4, ev); end
    else $display("ok   multi_disk2 ed_page=%0d", ed4);
    exp_q.push_back(8'h00);
    @(negedge clk_sys);
    ev = exp_q.pop_front(); total++;
    if ({7'b0, conf4} !== ev) begin bad++; $display("FAIL conflict_single got=%b want=%h", conf4, ev); end
    else $display("ok   conflict_single conflict=%b", conf4);
    ram_read = 1'b0;
  endtask

  task automatic test_ext;
    logic [15:0] addrs [4] = '{16'h9000, 16'h8000, 16'hA000, 16'h9000};
    logic        rrs   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        wns   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0]  exps  [4] = '{8'd2, 8'd2, 8'd0, 8'd0};
    wr(8'h10, 8'h41);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exps[i]);
      bus(addrs[i], rrs[i], wns[i], 1'b0);
      ev = exp_q.pop_front(); total++;
      if ({5'b0, ede} !== ev || ed1 !== 3'd0) begin
        bad++; $display("FAIL ext_window addr=%h got=%0d (no-ext %0d) want=%0d", addrs[i], ede, ed1, ev);
      end else $display("ok   ext_window addr=%h ed_page=%0d no-ext=%0d", addrs[i], ede, ed1);
    end
    ram_read = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_bad_port;
    @(posedge clk_sys); #1;
    io_addr = 8'h11; din = 8'hAA; io_wr = 1'b1;
    exp_q.push_back(8'h00);
    @(negedge clk_sys);
    ev = exp_q.pop_front(); total++;
    if ({7'b0, sel1} !== ev) begin bad++; $display("FAIL bad_port_sel got=%b want=%h", sel1, ev); end
    else $display("ok   bad_port_sel sel=%b", sel1);
    @(posedge clk_sys); #1;
    io_wr = 1'b0; io_rd = 1'b1;
    exp_q.push_back(8'hFF);
    @(negedge clk_sys);
    ev = exp_q.pop_front(); total++;
    if (dout1 !== ev) begin bad++; $display("FAIL bad_port_dout got=%h want=%h", dout1, ev); end
    else $display("ok   bad_port_dout dout=%h", dout1);
    exp_q.push_back(8'hAA);
    ev = exp_q.pop_front(); total++;
    if (dout4 !== ev) begin bad++; $display("FAIL port11_4disk got=%h want=%h", dout4, ev); end
    else $display("ok   port11_4disk dout=%h", dout4);
    @(posedge clk_sys); #1;
    io_addr = 8'h10;
    exp_q.push_back(8'h41);
    @(negedge clk_sys);
    ev = exp_q.pop_front(); total++;
    if (dout1 !== ev) begin bad++; $display("FAIL bad_port_unchanged got=%h want=%h", dout1, ev); end
    else $display("ok   bad_port_unchanged dout=%h", dout1);
    io_rd = 1'b0;
  endtask

  task automatic test_reset_mid_write;
    @(posedge clk_sys); #1;
    io_addr = 8'h10; din = 8'h77; io_wr = 1'b1; reset = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1 io_wr = 1'b0; io_rd = 1'b1;
    exp_q.push_back(8'h00);
    @(negedge clk_sys);
    ev = exp_q.pop_front(); total++;
    if (dout1 !== ev || doute !== ev) begin bad++; $display("FAIL reset_mid_write got=%h/%h want=%h", dout1, doute, ev); end
    else $display("ok   reset_mid_write dout=%h", dout1);
    io_rd = 1'b0;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(d);
      wr(8'(8'h10 + i), d);
    end
    io_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_sys); #1;
      io_addr = 8'(8'h10 + i);
      @(negedge clk_sys);
      ev = exp_q.pop_front(); total++;
      if (dout4 !== ev) begin bad++; $display("FAIL b2b_port%0d got=%h want=%h", i, dout4, ev); end
      else $display("ok   b2b_port%0d dout=%h", i, dout4);
    end
    io_rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; io_addr = 8'h00; io_wr = 1'b0; io_rd = 1'b0; din = 8'h00;
    addr = 16'h0000; ram_read = 1'b0; write_n = 1'b1; io_stack = 1'b0;
    test_reset;
    test_window;
    test_stack;
    test_multi;
    test_ext;
    test_bad_port;
    test_reset_mid_write;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
